// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared trellis constants, types and helpers for encoder and decoder
package viterbi_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  localparam logic [2:0] G0_DEFAULT = 3'b111;
  localparam logic [2:0] G1_DEFAULT = 3'b101;

  // Row order matches the decoder's survivor memory: value = {s1,s0}
  typedef enum logic [1:0] {
    ST_00 = 2'b00,
    ST_01 = 2'b01,
    ST_10 = 2'b10,
    ST_11 = 2'b11
  } trellis_t;

  typedef logic [1:0] sym_t;

  typedef enum logic {
    DATA = 1'b0,
    TAIL = 1'b1
  } enc_state_e;

  function automatic logic parity3(input logic [2:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_framer_if.sv
// rtl/conv_encoder_framer_if.sv - bit-in / symbol-out handshake bundle of the encoder framer
interface conv_encoder_framer_if;
  import viterbi_pkg::*;

  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic flush;
  logic out_valid;
  sym_t out_sym;
  logic out_ready;
  logic out_first;
  logic out_last;

  // Upstream source and downstream sink view
  modport master (
    output in_valid, in_bit, flush, out_ready,
    input  in_ready, out_valid, out_sym, out_first, out_last
  );

  // Encoder view
  modport slave (
    input  in_valid, in_bit, flush, out_ready,
    output in_ready, out_valid, out_sym, out_first, out_last
  );

endinterface

// File: rtl/conv_enc_step.sv
// rtl/conv_enc_step.sv - one trellis step: code symbol and next state for input u
module conv_enc_step
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEFAULT,
  parameter logic [2:0] G1 = G1_DEFAULT
) (
  input  logic     u,
  input  trellis_t state,
  output sym_t     sym,
  output trellis_t next_state
);

  logic [2:0] taps;

  // Taps are {u,s1,s0}; the new s1 is u and the old s1 slides into s0
  always_comb begin
    taps       = {u, state};
    sym        = {parity3(G0 & taps), parity3(G1 & taps)};
    next_state = trellis_t'({u, taps[1]});
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// rtl/conv_encoder_framer.sv - rate-1/2 K=3 convolutional encoder with zero-tail frame builder
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int          DATA_LEN = 6,
  parameter logic [2:0]  G0       = G0_DEFAULT,
  parameter logic [2:0]  G1       = G1_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  conv_encoder_framer_if.slave bus
);

  localparam int             CW        = $clog2(DATA_LEN + 2);
  localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_LEN - 1);
  localparam logic           LAST_TAIL = 1'(TAIL_LEN - 1);

  enc_state_e    state_q, state_d;
  trellis_t      shift_q, shift_d, step_next;
  logic [CW-1:0] count_q, count_d;
  logic          tail_idx_q, tail_idx_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  sym_t          out_sym_q, out_sym_d, step_sym;
  logic          slot_free;
  logic          accept;
  logic          step_u;

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (state_q == DATA) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  // Tail steps feed zeros so the frame terminates in ST_00
  assign step_u       = (state_q == DATA) ? bus.in_bit : 1'b0;

  conv_enc_step #(
    .G0 (G0),
    .G1 (G1)
  ) u_step (
    .u          (step_u),
    .state      (shift_q),
    .sym        (step_sym),
    .next_state (step_next)
  );

  // Next-state: accept data bits, then emit the zero tail, loading the single output stage
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    tail_idx_d  = tail_idx_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_sym_d   = out_sym_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    case (state_q)
      DATA: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_sym_d   = step_sym;
          out_first_d = (count_q == '0);
          out_last_d  = 1'b0;
          shift_d     = step_next;
          count_d     = count_q + 1'b1;
          // A flush alongside an accepted bit closes the frame after that bit
          if (count_q == LAST_DATA || bus.flush) begin
            state_d    = TAIL;
            tail_idx_d = 1'b0;
          end
        end else if (bus.flush && count_q != '0) begin
          state_d    = TAIL;
          tail_idx_d = 1'b0;
        end
      end
      TAIL: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_sym_d   = step_sym;
          out_first_d = 1'b0;
          out_last_d  = (tail_idx_q == LAST_TAIL);
          shift_d     = step_next;
          if (tail_idx_q == LAST_TAIL) begin
            state_d    = DATA;
            count_d    = '0;
            tail_idx_d = 1'b0;
          end else begin
            tail_idx_d = tail_idx_q + 1'b1;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  // State and output register; reset abandons any open frame including its tail
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DATA;
      shift_q     <= ST_00;
      count_q     <= '0;
      tail_idx_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      tail_idx_q  <= tail_idx_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb/tb_conv_encoder_framer.sv - scoreboard bench for the convolutional encoder framer
module tb_conv_encoder_framer;
  import viterbi_pkg::*;

  typedef struct packed {
    logic [1:0] sym;
    logic       first;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  conv_encoder_framer_if bus ();

  conv_encoder_framer #(
    .DATA_LEN (6),
    .G0       (3'b111),
    .G1       (3'b101)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Every handshaken symbol is popped from the scoreboard and compared in order
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_symbol got sym=%b first=%b last=%b required=none",
                 bus.out_sym, bus.out_first, bus.out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.out_sym, bus.out_first, bus.out_last} !== mon_e) begin
          bad++;
          $display("FAIL symbol got {sym,first,last}=%b required=%b",
                   {bus.out_sym, bus.out_first, bus.out_last}, mon_e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [1:0] sym, input logic first, input logic last);
    exp_t e;
    e.sym   = sym;
    e.first = first;
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Expected symbols for data 1,0,1,1,0,0 starting from state 00
  task automatic push_nominal();
    push_exp(2'b11, 1'b1, 1'b0);
    push_exp(2'b10, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b11, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b1);
  endtask

  // Called and returns just after a rising edge
  task automatic drive_bit(input logic b, input logic fl);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.flush    = fl;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout got=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(bits[i], 1'b0);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    total++; if (bus.out_sym !== 2'b00) begin bad++; $display("FAIL reset_out_sym got=%b required=00", bus.out_sym); end
    total++; if (bus.out_first !== 1'b0) begin bad++; $display("FAIL reset_out_first got=%b required=0", bus.out_first); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b required=0", bus.out_last); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", bus.in_ready); end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    logic [2:0] rdy;
    push_nominal();
    send_bits(12'b000000_001101, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rdy[2-i] = bus.in_ready;
    end
    total++;
    if (rdy !== 3'b001) begin
      bad++;
      $display("FAIL nominal_tail_in_ready got=%b required=001", rdy);
    end
    @(posedge clk);
    #1;
    drain("nominal");
  endtask

  task automatic test_back_pressure();
    push_nominal();
    fork
      send_bits(12'b000000_001101, 6);
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!(bus.out_valid === 1'b1 && bus.out_sym === 2'b10) && n < 50);
        total++;
        if (n >= 50) begin
          bad++;
          $display("FAIL bp_second_symbol_timeout got sym=%b required=10", bus.out_sym);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          total++;
          if (bus.out_valid !== 1'b1 || bus.out_sym !== 2'b10 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got valid=%b sym=%b in_ready=%b required valid=1 sym=10 in_ready=0",
                     bus.out_valid, bus.out_sym, bus.in_ready);
          end
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("back_pressure");
  endtask

  task automatic test_early_flush();
    push_exp(2'b11, 1'b1, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b11, 1'b0, 1'b1);
    send_bits(12'b000000_000011, 2);
    pulse_flush();
    drain("early_flush");
    push_nominal();
    send_bits(12'b000000_001101, 6);
    drain("after_flush");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      push_exp(2'b11, 1'b1, 1'b0);
      push_exp(2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push_exp(2'b10, 1'b0, 1'b0);
      push_exp(2'b01, 1'b0, 1'b0);
      push_exp(2'b11, 1'b0, 1'b1);
    end
    fork
      send_bits(12'b111111_111111, 12);
      begin
        int n;
        int idle;
        n = 0;
        idle = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 16; i++) begin
          if (bus.out_valid !== 1'b1) idle++;
          @(negedge clk);
        end
        total++;
        if (idle != 0) begin
          bad++;
          $display("FAIL b2b_idle_cycles got=%0d required=0", idle);
        end
      end
    join
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_tail();
    int seen;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) push_exp(2'b11, 1'b1, 1'b0);
      else if (i == 1) push_exp(2'b10, 1'b0, 1'b0);
      else if (i == 2) push_exp(2'b00, 1'b0, 1'b0);
      else if (i == 5) push_exp(2'b11, 1'b0, 1'b0);
      else if (i == 6) push_exp(2'b00, 1'b0, 1'b0);
      else push_exp(2'b01, 1'b0, 1'b0);
    end
    send_bits(12'b000000_001101, 6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_tail_out_valid got=%b required=0", bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_tail_leftover got valid_cycles=%0d pending=%0d required 0 0", seen, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    push_exp(2'b11, 1'b1, 1'b0);
    push_exp(2'b10, 1'b0, 1'b0);
    push_exp(2'b11, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    pulse_flush();
    drain("after_reset");
  endtask

  task automatic test_flush_corners();
    int seen;
    pulse_flush();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_flush got valid_cycles=%0d in_ready=%b required 0 1", seen, bus.in_ready);
    end
    @(posedge clk);
    #1;
    push_exp(2'b11, 1'b1, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b01, 1'b0, 1'b0);
    push_exp(2'b11, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    drain("flush_with_bit");
    push_nominal();
    send_bits(12'b000000_001101, 5);
    drive_bit(1'b0, 1'b1);
    pulse_flush();
    drain("flush_in_tail");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_back_pressure();
    test_early_flush();
    test_back_to_back();
    test_reset_mid_tail();
    test_flush_corners();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Transmit-side companion to the Viterbi decoder: rate-1/2, constraint-length-3 convolutional encoder with frame builder.
- Accepts a serial data stream and emits 2-bit code symbols.
- Appends K-1 zero tail bits per frame so every frame terminates in trellis state 00, which the decoder's traceback assumes.
- One frame equals the decoder's 8-stage trellis depth by default: 6 data symbols plus 2 tail symbols.

Parameters:
- DATA_LEN, 6, data bits per frame (>=1); frame length = DATA_LEN+2 symbols.
- G0, 3'b111, generator polynomial for symbol bit 1 (bit2 = current input, bit1 = s1, bit0 = s0).
- G1, 3'b101, generator polynomial for symbol bit 0, same bit mapping.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data bit offered.
- in_bit  in  1  data bit.
- in_ready  out  1  encoder accepts in_bit this cycle.
- flush  in  1  single-cycle request to terminate the current frame early.
- out_valid  out  1  out_sym holds a valid symbol.
- out_sym  out  2  code symbol {c0,c1}; c0 = parity(G0 & {u,s1,s0}), c1 = parity(G1 & {u,s1,s0}).
- out_ready  in  1  downstream consumes symbol when high with out_valid.
- out_first  out  1  qualifies first symbol of a frame.
- out_last  out  1  qualifies final tail symbol of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_sym=2'b00, out_first=0, out_last=0.
  - Shift state {s1,s0}=00, symbol counter=0, FSM=DATA.
  - in_ready is combinational and reads 0 while rst=1.
- Shift state: s1 = most recent input, s0 = the one before. On each encode step with input u: {s1,s0} <= {u,s1}.
- Output register: a single holding stage. slot_free = !out_valid || out_ready. While out_valid=1 && out_ready=0, out_sym, out_first and out_last hold stable.
- FSM state DATA:
  - in_ready = slot_free.
  - On in_valid && in_ready: encode in_bit, load the output register (visible the cycle after acceptance; latency 1), counter++.
  - out_first=1 when counter was 0.
  - When the accepted bit is data bit DATA_LEN, go to TAIL.
- FSM state TAIL:
  - in_ready=0.
  - Each cycle with slot_free, encode u=0 internally and load the output register.
  - The second tail symbol has out_last=1. On it, counter<=0 and FSM goes to DATA; the shift state is 00 by construction.
- Throughput: one symbol per clock under continuous out_ready=1, including the DATA->TAIL->DATA boundaries (no bubbles).
- flush behaviour:
  - flush in DATA with counter>0: FSM goes to TAIL at the next edge; the frame is truncated to the bits accepted so far plus 2 tail symbols.
  - flush and a bit accepted in the same cycle: the bit is encoded first, then TAIL.
  - flush with counter==0 (no frame open), or while in TAIL: ignored.
  - flush coinciding with acceptance of data bit DATA_LEN: normal transition, no extra tail.
- No-data case: in_valid=0 in DATA leaves state, counter and output unchanged apart from handshake drain (out_valid clears when consumed and nothing new is loaded).
- Reset mid-frame, including mid-TAIL: the frame is abandoned, no remaining tail symbols are emitted, and the next accepted bit starts a fresh frame from state 00 with out_first=1.
- Counter width: $clog2(DATA_LEN+2); it never exceeds DATA_LEN+1.

Decomposition:
- Shared package viterbi_pkg:
  - K=3, TAIL_LEN=K-1, default G0/G1.
  - 2-bit trellis state type with encodings ST_00, ST_01, ST_10, ST_11, matching the decoder's survivor-memory row order.
  - 2-bit symbol type.
  - Encoder FSM enum {DATA, TAIL}.
- One sub-module: conv_enc_step, combinational; inputs u and {s1,s0}, outputs the symbol and next state. The branch-metric unit reuses it to generate expected symbols.

Test Plan:
- Nominal frame: in_bit 1,0,1,1,0,0 with out_ready=1 -> out_sym 11,10,00,01,01,11,00,00 on consecutive cycles; out_first on the 1st, out_last on the 8th; in_ready=0 for 2 cycles during tail.
- Back-pressure: hold out_ready=0 for 3 cycles after the 2nd symbol -> out_sym stays 10, in_ready=0, no symbol lost or duplicated; the stream resumes as in the nominal test.
- Early flush: bits 1,1 then flush -> 11,01,01,11 with out_last on the 4th; the next frame starts with out_first=1 from state 00.
- Back-to-back frames: 12 bits of all 1s with continuous valid/ready -> 11,01,10,10,10,10,01,11 repeated twice, with no idle cycle between frames.
- Reset mid-tail: assert rst after the first tail symbol -> out_valid=0 next cycle, no second tail symbol; the following bit 1 yields 11 with out_first=1.
- Flush corner cases: flush with no frame open is ignored (no output); flush during TAIL does not extend the tail (still exactly 2 tail symbols).
